// File: rtl/ecdsa_sign_sequencer_if.sv
// Handshake and control bundle between the ECDSA sign sequencer,
// its host and the sign datapath.
interface ecdsa_sign_sequencer_if #(
    parameter int NONCE_CTR_W = 32
);
    logic                   start;
    logic                   abort;
    logic                   ready;
    logic                   hash_start;
    logic                   done_hash;
    logic                   load_hash;
    logic                   chacha_run;
    logic                   done_chacha;
    logic                   point_run;
    logic                   done_gen_point;
    logic                   r_zero;
    logic                   inv_run;
    logic                   done_mod;
    logic                   mul_run;
    logic                   done_sig;
    logic                   s_zero;
    logic                   sig_valid;
    logic                   sig_ack;
    logic [1:0]             status;
    logic [NONCE_CTR_W-1:0] nonce_ctr;
    logic [3:0]             retry_cnt;

    modport master (
        input  start, abort, done_hash, done_chacha, done_gen_point,
        input  r_zero, done_mod, done_sig, s_zero, sig_ack,
        output ready, hash_start, load_hash, chacha_run, point_run,
        output inv_run, mul_run, sig_valid, status, nonce_ctr, retry_cnt
    );

    modport slave (
        output start, abort, done_hash, done_chacha, done_gen_point,
        output r_zero, done_mod, done_sig, s_zero, sig_ack,
        input  ready, hash_start, load_hash, chacha_run, point_run,
        input  inv_run, mul_run, sig_valid, status, nonce_ctr, retry_cnt
    );
endinterface

// File: rtl/ecdsa_sign_sequencer.sv
// ECDSA sign control FSM: hash, nonce, k*G, inverse, multiply, retry on r/s==0.
// Optional per-stage watchdog enabled by defining ECDSA_SIGN_TIMEOUT_EN.
module ecdsa_sign_sequencer #(
    parameter int MAX_RETRY      = 8,
    parameter int NONCE_CTR_W    = 32,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                   clk,
    input  logic                   reset_n,
    ecdsa_sign_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        HASH    = 4'd1,
        LOADH   = 4'd2,
        NONCE   = 4'd3,
        POINT   = 4'd4,
        CHECK_R = 4'd5,
        INVERT  = 4'd6,
        SIGN    = 4'd7,
        CHECK_S = 4'd8,
        RETRY   = 4'd9,
        DONE    = 4'd10,
        FAIL    = 4'd11
    } state_e;

    localparam logic [1:0] StOk      = 2'b00;
    localparam logic [1:0] StRetries = 2'b01;
    localparam logic [1:0] StTimeout = 2'b10;
    localparam logic [3:0] MaxRetry  = 4'(MAX_RETRY);

    state_e                 state_q, state_d;
    logic                   hash_start_q, hash_start_d;
    logic [1:0]             status_q, status_d;
    logic [NONCE_CTR_W-1:0] nonce_ctr_q, nonce_ctr_d;
    logic [3:0]             retry_cnt_q, retry_cnt_d;
    logic                   tmo_hit;

`ifdef ECDSA_SIGN_TIMEOUT_EN
    localparam int TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            wait_st;

    always_comb begin
        wait_st = state_q inside {HASH, NONCE, POINT, INVERT, SIGN};
        tmo_hit = wait_st && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        tmo_cnt_d = '0;
        if (wait_st && (state_d == state_q)) begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;

    // Watchdog limit is only meaningful with the watchdog built in.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
    end
`endif

    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        nonce_ctr_d  = nonce_ctr_q;
        retry_cnt_d  = retry_cnt_q;
        hash_start_d = 1'b0;

        if ((state_q != IDLE) && bus.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d      = HASH;
                        status_d     = StOk;
                        nonce_ctr_d  = '0;
                        retry_cnt_d  = '0;
                        hash_start_d = 1'b1;
                    end
                end
                HASH: begin
                    if (bus.done_hash) state_d = LOADH;
                end
                LOADH: begin
                    state_d = NONCE;
                end
                NONCE: begin
                    if (bus.done_chacha) state_d = POINT;
                end
                POINT: begin
                    if (bus.done_gen_point) state_d = CHECK_R;
                end
                CHECK_R: begin
                    state_d = bus.r_zero ? RETRY : INVERT;
                end
                INVERT: begin
                    if (bus.done_mod) state_d = SIGN;
                end
                SIGN: begin
                    if (bus.done_sig) state_d = CHECK_S;
                end
                CHECK_S: begin
                    if (bus.s_zero) begin
                        state_d = RETRY;
                    end else begin
                        state_d  = DONE;
                        status_d = StOk;
                    end
                end
                RETRY: begin
                    // The hash is kept; only the nonce path is rerun.
                    nonce_ctr_d = nonce_ctr_q + NONCE_CTR_W'(1);
                    retry_cnt_d = retry_cnt_q + 4'd1;
                    if (retry_cnt_d > MaxRetry) begin
                        state_d  = FAIL;
                        status_d = StRetries;
                    end else begin
                        state_d = NONCE;
                    end
                end
                DONE, FAIL: begin
                    if (bus.sig_ack) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // A stage that completes in the same cycle wins over the watchdog.
            if (tmo_hit && (state_d == state_q)) begin
                state_d  = FAIL;
                status_d = StTimeout;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            hash_start_q <= 1'b0;
            status_q     <= StOk;
            nonce_ctr_q  <= '0;
            retry_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            hash_start_q <= hash_start_d;
            status_q     <= status_d;
            nonce_ctr_q  <= nonce_ctr_d;
            retry_cnt_q  <= retry_cnt_d;
        end
    end

    always_comb begin
        bus.ready      = (state_q == IDLE);
        bus.hash_start = hash_start_q;
        bus.load_hash  = (state_q == LOADH);
        bus.chacha_run = state_q inside {NONCE, POINT, CHECK_R, INVERT,
                                         SIGN, CHECK_S, DONE};
        bus.point_run  = state_q inside {POINT, CHECK_R, INVERT, SIGN,
                                         CHECK_S, DONE};
        bus.inv_run    = state_q inside {INVERT, SIGN, CHECK_S, DONE};
        bus.mul_run    = state_q inside {SIGN, CHECK_S, DONE};
        bus.sig_valid  = state_q inside {DONE, FAIL};
        bus.status     = status_q;
        bus.nonce_ctr  = nonce_ctr_q;
        bus.retry_cnt  = retry_cnt_q;
    end

endmodule

// File: tb/tb_ecdsa_sign_sequencer.sv
// Scoreboard bench for ecdsa_sign_sequencer with a behavioural datapath model.
// Random delays and r/s zero patterns; the request outcome is predicted per attempt.
`timescale 1ns/1ps
module tb_ecdsa_sign_sequencer;

    localparam int MAXR = 2;
    localparam int NCW  = 8;
    localparam int TMO  = 16;

    typedef struct {
        logic [1:0]     st;
        logic [3:0]     rc;
        logic [NCW-1:0] nc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ecdsa_sign_sequencer_if #(.NONCE_CTR_W(NCW)) bus ();

    ecdsa_sign_sequencer #(
        .MAX_RETRY     (MAXR),
        .NONCE_CTR_W   (NCW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk    (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Datapath model: each unit answers a programmable number of cycles after its run.
    int          hdly, cdly, pdly, idly, mdly;
    int          hcnt, ccnt, pcnt, icnt, mcnt;
    bit          hbusy;
    bit          hang;
    logic [15:0] r_pat, s_pat;
    int          att;
    logic        cprev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hbusy <= 1'b0;
            hcnt  <= 0;
            ccnt  <= 0;
            pcnt  <= 0;
            icnt  <= 0;
            mcnt  <= 0;
            cprev <= 1'b0;
            att   <= -1;
        end else begin
            if (bus.hash_start) begin
                hbusy <= 1'b1;
                hcnt  <= 1;
            end else if (bus.load_hash || bus.ready) begin
                hbusy <= 1'b0;
                hcnt  <= 0;
            end else if (hbusy) begin
                hcnt <= hcnt + 1;
            end
            ccnt  <= bus.chacha_run ? ccnt + 1 : 0;
            pcnt  <= bus.point_run  ? pcnt + 1 : 0;
            icnt  <= bus.inv_run    ? icnt + 1 : 0;
            mcnt  <= bus.mul_run    ? mcnt + 1 : 0;
            cprev <= bus.chacha_run;
            if (bus.ready) att <= -1;
            else if (bus.chacha_run && !cprev) att <= att + 1;
        end
    end

    assign bus.done_hash      = (bus.hash_start && hdly == 0) ||
                                (hbusy && hcnt >= hdly);
    assign bus.done_chacha    = bus.chacha_run && ccnt >= cdly;
    assign bus.done_gen_point = bus.point_run && !hang && pcnt >= pdly;
    assign bus.done_mod       = bus.inv_run && icnt >= idly;
    assign bus.done_sig       = bus.mul_run && mcnt >= mdly;
    assign bus.r_zero = (att >= 0 && att < 16) ? r_pat[att[3:0]] : 1'b0;
    assign bus.s_zero = (att >= 0 && att < 16) ? s_pat[att[3:0]] : 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Outcome of one request: every attempt with r==0 or s==0 costs a retry.
    function automatic exp_t model();
        exp_t e;
        int   fails = 0;
        for (int a = 0; a < 16; a++) begin
            if (!r_pat[a] && !s_pat[a]) begin
                e = '{st: 2'b00, rc: 4'(fails), nc: NCW'(fails)};
                return e;
            end
            fails++;
            if (fails > MAXR) begin
                e = '{st: 2'b01, rc: 4'(fails), nc: NCW'(fails)};
                return e;
            end
        end
        e = '{st: 2'b01, rc: 4'(fails), nc: NCW'(fails)};
        return e;
    endfunction

    exp_t expq[$];
    bit   seen;
    int   hs_cnt;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen   = 1'b0;
            hs_cnt = 0;
        end else begin
            if (bus.ready) hs_cnt = 0;
            if (bus.hash_start) hs_cnt++;
            if (!bus.sig_valid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_sig_valid actual=1 required=0");
                end else begin
                    e = expq.pop_front();
                    chk("status", 32'(bus.status), 32'(e.st));
                    chk("retry_cnt", 32'(bus.retry_cnt), 32'(e.rc));
                    chk("nonce_ctr", 32'(bus.nonce_ctr), 32'(e.nc));
                    chk("hash_starts", 32'(hs_cnt), 32'd1);
                end
            end
        end
    end

    task automatic set_delays(input int lo, input int hi);
        hdly = $urandom_range(hi, lo);
        cdly = $urandom_range(hi, lo);
        pdly = $urandom_range(hi, lo);
        idly = $urandom_range(hi, lo);
        mdly = $urandom_range(hi, lo);
    endtask

    task automatic wait_for(input string name, input int which);
        int n = 0;
        logic hit;
        do begin
            case (which)
                0: hit = bus.point_run;
                1: hit = bus.inv_run;
                default: hit = bus.mul_run;
            endcase
            if (!hit) begin
                @(posedge clk);
                #1;
                n++;
            end
        end while (!hit && n < 200);
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=0 required=1", name);
        end
    endtask

    task automatic do_req(input exp_t e, input bit chk_lat, input int lat_exp);
        int lat;
        expq.push_back(e);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.sig_valid && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.sig_valid) begin
            checks++;
            failures++;
            $display("FAIL sig_valid_wait actual=0 required=1");
            expq.delete();
            return;
        end
        if (chk_lat) chk("latency", 32'(lat), 32'(lat_exp));
        repeat ($urandom_range(3, 0)) @(posedge clk);
        #1;
        bus.sig_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.sig_ack = 1'b0;
        chk("ready_after_ack", 32'(bus.ready), 32'd1);
        chk("valid_after_ack", 32'(bus.sig_valid), 32'd0);
    endtask

    function automatic logic [7:0] out_vec();
        return {bus.ready, bus.hash_start, bus.load_hash, bus.chacha_run,
                bus.point_run, bus.inv_run, bus.mul_run, bus.sig_valid};
    endfunction

    initial begin
        exp_t e;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.sig_ack = 1'b0;
        hang  = 1'b0;
        r_pat = '0;
        s_pat = '0;
        set_delays(0, 0);

        #1;
        chk("reset_outputs", 32'(out_vec()), 32'h80);
        chk("reset_status", 32'(bus.status), 32'd0);
        chk("reset_nonce", 32'(bus.nonce_ctr), 32'd0);
        chk("reset_retry", 32'(bus.retry_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal, every unit answers immediately.
        do_req(model(), 1'b1, 9);

        // r==0 on the first attempt.
        r_pat = 16'h0001;
        do_req(model(), 1'b1, 13);

        // s==0 on every attempt exhausts the retries.
        r_pat = '0;
        s_pat = 16'hffff;
        do_req(model(), 1'b1, 24);

        // Abort in INVERT together with done_mod.
        s_pat = '0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_for("inv_run", 1);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_inv_run", 32'(bus.inv_run), 32'd0);
        chk("abort_valid", 32'(bus.sig_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        do_req(model(), 1'b1, 9);

        // start while busy is ignored; async reset in SIGN.
        r_pat = 16'h0001;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_for("point_run", 0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_no_hash_start", 32'(bus.hash_start), 32'd0);
        chk("busy_not_ready", 32'(bus.ready), 32'd0);
        wait_for("mul_run", 2);
        chk("retried_nonce", 32'(bus.nonce_ctr), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(out_vec()), 32'h80);
        chk("async_reset_nonce", 32'(bus.nonce_ctr), 32'd0);
        chk("async_reset_retry", 32'(bus.retry_cnt), 32'd0);
        expq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        r_pat = '0;

        // Randomized requests.
        for (int i = 0; i < 24; i++) begin
            set_delays(0, 3);
            r_pat = '0;
            s_pat = '0;
            for (int a = 0; a < 16; a++) begin
                r_pat[a] = ($urandom_range(3, 0) == 0);
                s_pat[a] = ($urandom_range(3, 0) == 0);
            end
            do_req(model(), 1'b0, 0);
        end

`ifdef ECDSA_SIGN_TIMEOUT_EN
        // gen_point never finishes; the watchdog ends the request.
        set_delays(0, 0);
        r_pat = '0;
        s_pat = '0;
        hang  = 1'b1;
        e = '{st: 2'b10, rc: 4'd0, nc: NCW'(0)};
        do_req(e, 1'b1, 3 + TMO + 1);
        hang = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
